// File: rtl/inference_argmax_seq_pkg.sv
// Shared types and sizing for the inference argmax sequencer.
// Score width, class count and the sequencer state encoding.
package dnn_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    localparam logic [IDX_W-1:0] TIMEOUT_CLASS = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        WAIT,
        SCAN,
        RESULT
    } state_t;

endpackage

// File: rtl/inference_argmax_seq_if.sv
// Request, engine and result signals of the argmax sequencer.
// master is the sequencer side, slave is the requester/engine side.
interface inference_argmax_seq_if #(
    parameter int DATA_WIDTH = dnn_pkg::DATA_WIDTH
);

    logic                         req_valid;
    logic                         req_ready;
    logic                         eng_reset;
    logic                         eng_start;
    logic                         eng_done;
    logic [3:0]                   eng_idx;
    logic signed [DATA_WIDTH-1:0] eng_out;
    logic                         res_valid;
    logic                         res_ready;
    logic [3:0]                   res_class;
    logic signed [DATA_WIDTH-1:0] res_score;
    logic                         res_timeout;
    logic                         busy;

    modport master (
        input  req_valid,
        output req_ready,
        output eng_reset,
        output eng_start,
        input  eng_done,
        output eng_idx,
        input  eng_out,
        output res_valid,
        input  res_ready,
        output res_class,
        output res_score,
        output res_timeout,
        output busy
    );

    modport slave (
        output req_valid,
        input  req_ready,
        input  eng_reset,
        input  eng_start,
        output eng_done,
        input  eng_idx,
        output eng_out,
        input  res_valid,
        output res_ready,
        input  res_class,
        input  res_score,
        input  res_timeout,
        input  busy
    );

endinterface

// File: rtl/inference_argmax_seq_acc.sv
// Running argmax over sampled scores.
// Ties keep the earlier index because only strict greater-than replaces.
module argmax_acc #(
    parameter int DATA_WIDTH = dnn_pkg::DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         sample,
    input  logic [3:0]                   idx,
    input  logic signed [DATA_WIDTH-1:0] value,
    output logic [3:0]                   best_idx,
    output logic signed [DATA_WIDTH-1:0] best_val
);

    logic take;

    assign take = sample && ((idx == 4'd0) || (value > best_val));

    always_ff @(posedge clk) begin
        if (clear) begin
            best_idx <= '0;
            best_val <= '0;
        end else if (take) begin
            best_idx <= idx;
            best_val <= value;
        end
    end

endmodule

// File: rtl/inference_argmax_seq.sv
// Sequencer: clears and launches the engine, waits for completion,
// scans every class score and holds the winning class until accepted.
module inference_argmax_seq #(
    parameter int DATA_WIDTH     = dnn_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES    = dnn_pkg::NUM_CLASSES,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                    clk,
    input logic                    rst,
    inference_argmax_seq_if.master bus
);

    import dnn_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                       state;
    state_t                       state_nx;
    logic [IDX_W-1:0]             scan_idx;
    logic [CW-1:0]                cnt;
    logic                         timed_out;
    logic                         expire;
    logic                         last_idx;
    logic [IDX_W-1:0]             best_idx;
    logic signed [DATA_WIDTH-1:0] best_val;

    assign last_idx = (scan_idx == IDX_W'(NUM_CLASSES - 1));

    always_comb begin
        state_nx = state;
        expire   = 1'b0;
        unique case (state)
            IDLE:   if (bus.req_valid) state_nx = CLEAR;
            CLEAR:  state_nx = LAUNCH;
            LAUNCH: state_nx = WAIT;
            WAIT: begin
                if (bus.eng_done) begin
                    state_nx = SCAN;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = RESULT;
                    expire   = 1'b1;
                end
            end
            SCAN:   if (last_idx) state_nx = RESULT;
            RESULT: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cnt counts completed WAIT cycles; it is zero on the first one
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            scan_idx  <= '0;
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= (state == WAIT) ? cnt + CW'(1) : '0;
            scan_idx <= (state == SCAN) ? scan_idx + IDX_W'(1) : '0;
            if (state == CLEAR) begin
                timed_out <= 1'b0;
            end else if (expire) begin
                timed_out <= 1'b1;
            end
        end
    end

    argmax_acc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_acc (
        .clk     (clk),
        .clear   (rst || (state == CLEAR)),
        .sample  (state == SCAN),
        .idx     (scan_idx),
        .value   (bus.eng_out),
        .best_idx(best_idx),
        .best_val(best_val)
    );

    assign bus.req_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.eng_reset   = (state == CLEAR);
    assign bus.eng_start   = (state == LAUNCH);
    assign bus.eng_idx     = (state == SCAN) ? scan_idx : '0;
    assign bus.res_valid   = (state == RESULT);
    assign bus.res_timeout = timed_out;
    assign bus.res_class   = timed_out ? TIMEOUT_CLASS : best_idx;
    assign bus.res_score   = timed_out ? '0 : best_val;

endmodule

// File: tb/tb_inference_argmax_seq.sv
// Scoreboarded bench for inference_argmax_seq with an engine model.
// A second instance with a short timeout covers the abort path.
module tb_inference_argmax_seq;

    localparam int NC = 10;
    localparam int TO_SHORT = 16;

    typedef struct {
        logic [3:0]        cls;
        logic signed [7:0] score;
        logic              to;
    } exp_t;

    logic clk;
    logic rst;

    inference_argmax_seq_if #(.DATA_WIDTH(8)) b ();
    inference_argmax_seq_if #(.DATA_WIDTH(8)) t ();

    inference_argmax_seq #(
        .DATA_WIDTH(8), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(32)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(b)
    );

    inference_argmax_seq #(
        .DATA_WIDTH(8), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO_SHORT)
    ) u_to (
        .clk(clk), .rst(rst), .bus(t)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic signed [7:0] scores[16];
    int delay = 5;
    int cd = -1;
    int rr_mode = 0;
    logic done_r = 1'b0;
    logic stuck = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // engine: done rises a programmable time after start, cleared by reset
    always @(posedge clk) begin
        if (b.eng_reset) begin
            done_r <= 1'b0;
            cd     <= -1;
        end else if (b.eng_start) begin
            cd <= delay;
        end else if (cd > 0) begin
            cd <= cd - 1;
        end else if (cd == 0) begin
            done_r <= 1'b1;
            cd     <= -1;
        end
    end

    assign b.eng_done = done_r | stuck;
    assign b.eng_out  = scores[b.eng_idx];
    assign t.eng_done = 1'b0;
    assign t.eng_out  = 8'sd0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic exp_t ref_model();
        exp_t e;
        int mx = -1000;
        for (int i = 0; i < NC; i++) if (scores[i] > mx) mx = scores[i];
        e.cls = 4'd0;
        for (int i = NC - 1; i >= 0; i--) if (scores[i] == mx) e.cls = 4'(i);
        e.score = 8'(mx);
        e.to    = 1'b0;
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, b.req_ready, 1);
        check({tag, "_busy"}, b.busy, 0);
        check({tag, "_eng_reset"}, b.eng_reset, 0);
        check({tag, "_eng_start"}, b.eng_start, 0);
        check({tag, "_eng_idx"}, b.eng_idx, 0);
        check({tag, "_res_valid"}, b.res_valid, 0);
        check({tag, "_res_class"}, b.res_class, 0);
        check({tag, "_res_score"}, b.res_score, 0);
        check({tag, "_res_timeout"}, b.res_timeout, 0);
    endtask

    task automatic rand_scores(input bool_narrow);
        int v;
        for (int i = 0; i < 16; i++) begin
            if (bool_narrow) v = int'($urandom_range(0, 4)) - 2;
            else v = int'($urandom);
            scores[i] = 8'(v);
        end
    endtask

    task automatic issue(input bit push);
        int n = 0;
        @(negedge clk);
        while (!b.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b.req_ready) check("req_ready_wait", 0, 1);
        if (push) exp_q.push_back(ref_model());
        b.req_valid = 1'b1;
        @(posedge clk);
        #1 b.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && b.req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_wait", 0, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: b.res_ready = ($urandom_range(0, 2) != 0);
                1: b.res_ready = 1'b0;
                default: b.res_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && b.eng_reset && b.eng_start) check("eng_excl", 1, 0);
        if (!rst && b.res_valid && b.res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_class", b.res_class, e.cls);
                check("res_score", b.res_score, e.score);
                check("res_timeout", b.res_timeout, e.to);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hc;
        logic signed [7:0] hs;
        int k;
        rst = 1'b1;
        b.req_valid = 1'b0;
        b.res_ready = 1'b0;
        t.req_valid = 1'b0;
        t.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) scores[i] = 8'sd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        scores[0] = 3; scores[1] = -5; scores[2] = 7; scores[3] = 7;
        scores[4] = 1; scores[5] = 0; scores[6] = -128; scores[7] = 2;
        scores[8] = 6; scores[9] = 4;
        delay = 20;
        issue(1);
        wait_idle();

        for (int i = 0; i < 16; i++) scores[i] = -8'sd128;
        delay = 3;
        issue(1);
        wait_idle();

        for (int r = 0; r < 30; r++) begin
            rand_scores(r % 3 == 0);
            delay = $urandom_range(1, 25);
            issue(1);
            wait_idle();
        end

        rr_mode = 1;
        rand_scores(0);
        delay = 4;
        issue(1);
        k = 0;
        while (!b.res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hold_res_valid", b.res_valid, 1);
        hc = b.res_class;
        hs = b.res_score;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", b.res_valid, 1);
            check("hold_req_ready", b.req_ready, 0);
            check("hold_class", b.res_class, hc);
            check("hold_score", b.res_score, hs);
        end
        rr_mode = 2;
        k = 0;
        while (!(b.res_valid && b.res_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check("post_hs_req_ready", b.req_ready, 1);
        check("post_hs_res_valid", b.res_valid, 0);
        rr_mode = 0;

        rand_scores(0);
        delay = 6;
        issue(0);
        k = 0;
        @(negedge clk);
        while (!(b.busy && b.eng_idx == 4'd4) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("scan_idx4_seen", b.eng_idx, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midscan");
        @(negedge clk);
        rst = 1'b0;
        rand_scores(1);
        delay = 8;
        issue(1);
        wait_idle();

        stuck = 1'b1;
        rand_scores(0);
        issue(1);
        @(negedge clk);
        check("stuck_eng_reset_t1", b.eng_reset, 1);
        check("stuck_eng_start_t1", b.eng_start, 0);
        @(negedge clk);
        check("stuck_eng_reset_t2", b.eng_reset, 0);
        check("stuck_eng_start_t2", b.eng_start, 1);
        k = 2;
        do begin
            @(negedge clk);
            k++;
        end while (!b.res_valid && k < 100);
        check("stuck_latency", k, 3 + NC + 1);
        wait_idle();
        stuck = 1'b0;

        @(negedge clk);
        t.req_valid = 1'b1;
        @(posedge clk);
        #1 t.req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!t.res_valid && k < 100);
        check("to_latency", k, 2 + TO_SHORT + 1);
        check("to_class", t.res_class, 15);
        check("to_score", t.res_score, 0);
        check("to_flag", t.res_timeout, 1);
        check("to_req_ready", t.req_ready, 0);
        t.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("to_post_req_ready", t.req_ready, 1);
        t.res_ready = 1'b0;

        wait_idle();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
